icache_fetch_ctrl: RTL and testbench



---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_line_array.sv | 54 +++++
 rtl/icache_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_icache_fetch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2
  } state_t;

  localparam int LINE_W    = 64;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int OFFS_BITS = 3;

  // Halfword position of an instruction inside its 4-word line.
  function automatic logic [1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[2:1];
  endfunction

  // Line number (address with the byte offset stripped); callers slice index and tag from it.
  function automatic logic [ADDR_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
    return a >> OFFS_BITS;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data flop storage for all cache lines, one read port and one write port.
// Latency: combinational read; write and clear take effect at the next clock edge.
// Backpressure: none; a write in the same cycle as clear-all lands valid.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 13 - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_all_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_vld_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [LINE_W-1:0]   rd_dat_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [LINE_W-1:0]   wr_dat_i
);

  localparam int NLINES = 1 << IDX_BITS;

  logic [NLINES-1:0]   valid_q;
  logic [NLINES-1:0]   valid_d;
  logic [TAG_BITS-1:0] tag_q  [NLINES];
  logic [LINE_W-1:0]   data_q [NLINES];

  // Clear-all is applied before the refill write so the new line survives.
  always_comb begin
    valid_d = clr_all_i ? '0 : valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
  end

  // Valid bits are the only reset state in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_dat_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped read-only I-cache with line refill FSM; optional counters under ICACHE_STATS_EN.
// Latency: hit answered same cycle; miss costs 3 stall cycles plus memory wait cycles.
// Backpressure: fetch_stall holds the fetch PC during a miss; mem_re/mem_addr held until mem_rdy.
module icache_fetch_ctrl
  import icache_pkg::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              inv_all,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_stall,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [LINE_W-1:0] mem_rd_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  // Tag width follows from the address split and is not a free parameter.
  localparam int TAG_BITS = ADDR_W - OFFS_BITS - IDX_BITS;

  state_t              state_q;
  logic [TAG_BITS-1:0] miss_tag_q;
  logic [IDX_BITS-1:0] miss_idx_q;
  logic [LINE_W-1:0]   line_q;
  logic                mem_re_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic [IDX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic [1:0]          word;
  logic                rd_vld;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_W-1:0]   rd_dat;
  logic                hit;
  logic                in_idle;
  logic                unused_addr_bit0;

  assign idx  = IDX_BITS'(addr_line(fetch_addr));
  assign tag  = TAG_BITS'(addr_line(fetch_addr) >> IDX_BITS);
  assign word = addr_word(fetch_addr);
  // Instructions are halfword aligned; the byte-select bit carries no information.
  assign unused_addr_bit0 = fetch_addr[0];

  icache_line_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_all_i (inv_all),
    .rd_idx_i  (idx),
    .rd_vld_o  (rd_vld),
    .rd_tag_o  (rd_tag),
    .rd_dat_o  (rd_dat),
    .wr_en_i   (state_q == REFILL),
    .wr_idx_i  (miss_idx_q),
    .wr_tag_i  (miss_tag_q),
    .wr_dat_i  (line_q)
  );

  assign hit     = fetch_req & rd_vld & (rd_tag == tag);
  assign in_idle = (state_q == IDLE);

  // Hits are served combinationally only from IDLE; every other state stalls fetch.
  assign instr_valid = in_idle & hit;
  assign instr       = instr_valid ? rd_dat[word*WORD_W +: WORD_W] : '0;
  assign fetch_stall = in_idle ? (fetch_req & ~hit) : 1'b1;
  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;

  // Refill FSM: latch the missing line, hold the memory request until data returns, then install.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      line_q     <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req && !hit) begin
            miss_tag_q <= tag;
            miss_idx_q <= idx;
            mem_re_q   <= 1'b1;
            mem_addr_q <= {tag, idx, OFFS_BITS'(0)};
            state_q    <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_rdy) begin
            line_q   <= mem_rd_data;
            mem_re_q <= 1'b0;
            state_q  <= REFILL;
          end
        end
        REFILL:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters; invalidation leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (in_idle) begin
      if (hit && hit_cnt != 16'hFFFF)                    hit_cnt  <= hit_cnt + 16'd1;
      if (fetch_req && !hit && miss_cnt != 16'hFFFF)     miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Self-checking bench for icache_fetch_ctrl against a line-level cache model.
// Latency: n/a.
// Backpressure: memory responder drives mem_rdy after a chosen number of wait cycles.
module tb_icache_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        inv_all;
  logic [15:0] instr;
  logic        instr_valid;
  logic        fetch_stall;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic [63:0] mem_rd_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one valid bit and one tag per index, plus event counters.
  bit         mvalid [8];
  logic [9:0] mtag   [8];
  int         m_hits   = 0;
  int         m_misses = 0;

  icache_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .inv_all     (inv_all),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_stall (fetch_stall),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_rdy     (mem_rdy),
    .mem_rd_data (mem_rd_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: line 0x0040 holds 1111/2222/3333/4444, others a address-derived pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] la, input int w);
    if (la == 16'h0040) return 16'(16'h1111 * (w + 1));
    return (la + 16'(w * 2)) ^ 16'hC3C3;
  endfunction

  function automatic logic [63:0] line_data(input logic [15:0] la);
    return {mem_word(la, 3), mem_word(la, 2), mem_word(la, 1), mem_word(la, 0)};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endfunction

  // One fetch from request to served word; inv_k >= 0 pulses inv_all on that stall cycle.
  task automatic do_fetch(input logic [15:0] a, input int waitc, input int inv_k, output int stalls);
    logic [2:0]  idx;
    logic [9:0]  tg;
    logic [15:0] la;
    bit          exp_hit;
    int          exp_stall;
    int          re_cycles;
    int          served;
    bit          done;
    idx       = a[5:3];
    tg        = a[15:6];
    la        = {a[15:3], 3'b000};
    exp_hit   = mvalid[idx] && (mtag[idx] == tg);
    exp_stall = exp_hit ? 0 : 3 + waitc;
    fetch_req  = 1'b1;
    fetch_addr = a;
    mem_rdy    = 1'b0;
    stalls     = 0;
    re_cycles  = 0;
    served     = 0;
    done       = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      inv_all = (!exp_hit && stalls == inv_k);
      #1;
      if (instr_valid) begin
        done = 1'b1;
      end else begin
        n_checks++;
        if (fetch_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_during_miss addr=%h got=%b exp=1", a, fetch_stall);
        end
        stalls++;
        if (mem_re) begin
          re_cycles++;
          n_checks++;
          if (mem_addr !== la) begin
            n_fail++;
            $display("FAIL mem_addr addr=%h got=%h exp=%h", a, mem_addr, la);
          end
          mem_rdy     = (served == waitc);
          mem_rd_data = line_data(la);
          served++;
        end else begin
          mem_rdy = 1'b0;
        end
        @(negedge clk);
      end
    end
    inv_all = 1'b0;
    mem_rdy = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL fetch_timeout addr=%h got=no_instr_valid exp=instr_valid", a);
    end
    n_checks++;
    if (stalls != exp_stall) begin
      n_fail++;
      $display("FAIL stall_count addr=%h got=%0d exp=%0d", a, stalls, exp_stall);
    end
    n_checks++;
    if (instr !== mem_word(la, int'(a[2:1]))) begin
      n_fail++;
      $display("FAIL instr addr=%h got=%h exp=%h", a, instr, mem_word(la, int'(a[2:1])));
    end
    n_checks++;
    if (re_cycles != (exp_hit ? 0 : 1 + waitc)) begin
      n_fail++;
      $display("FAIL mem_re_cycles addr=%h got=%0d exp=%0d", a, re_cycles, exp_hit ? 0 : 1 + waitc);
    end
    n_checks++;
    if (fetch_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_on_hit addr=%h got=%b exp=0", a, fetch_stall);
    end
    if (!exp_hit) begin
      if (inv_k >= 0 && inv_k <= 2 + waitc) model_clear();
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      m_misses++;
    end
    m_hits++;
    @(negedge clk);
  endtask

  task automatic pulse_inv();
    fetch_req = 1'b0;
    inv_all   = 1'b1;
    @(negedge clk);
    inv_all   = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({instr_valid, fetch_stall, mem_re} !== 3'b000 || mem_addr !== 16'h0 || instr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b%b%b/%h/%h exp=000/0000/0000", instr_valid, fetch_stall, mem_re, mem_addr, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({instr_valid, fetch_stall, mem_re} !== 3'b000 || instr !== 16'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b%b%b/%h exp=000/0000", instr_valid, fetch_stall, mem_re, instr);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fill();
    int st;
    do_fetch(16'h0040, 0, -1, st);
    n_checks++;
    if (st != 3) begin
      n_fail++;
      $display("FAIL first_fill_stalls got=%0d exp=3", st);
    end
  endtask

  task automatic test_seq_hits();
    int st;
    do_fetch(16'h0042, 0, -1, st);
    do_fetch(16'h0044, 0, -1, st);
    do_fetch(16'h0046, 0, -1, st);
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_cnt !== 16'd4 || miss_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_first_two got=hit%0d/miss%0d exp=hit4/miss1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_conflict();
    int st;
    do_fetch(16'h0440, 0, -1, st);
    do_fetch(16'h0040, 0, -1, st);
    n_checks++;
    if (st != 3) begin
      n_fail++;
      $display("FAIL conflict_refetch_stalls got=%0d exp=3", st);
    end
  endtask

  task automatic test_slow_mem();
    int st;
    do_fetch(16'h0106, 5, -1, st);
    n_checks++;
    if (st != 8) begin
      n_fail++;
      $display("FAIL slow_mem_stalls got=%0d exp=8", st);
    end
  endtask

  task automatic test_inv();
    int st;
    pulse_inv();
    do_fetch(16'h0040, 0, -1, st);
    n_checks++;
    if (st != 3) begin
      n_fail++;
      $display("FAIL inv_then_miss got=%0d exp=3", st);
    end
  endtask

  task automatic test_reset_mid_miss();
    int st;
    pulse_inv();
    fetch_req  = 1'b1;
    fetch_addr = 16'h0080;
    mem_rdy    = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_re !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_req_mem_re got=%b exp=1", mem_re);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_mem_re got=%b exp=0", mem_re);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    rst_n     = 1'b1;
    model_clear();
    m_hits   = 0;
    m_misses = 0;
    @(negedge clk);
    do_fetch(16'h0080, 0, -1, st);
    n_checks++;
    if (st != 3) begin
      n_fail++;
      $display("FAIL line_valid_after_reset got=%0d exp=3", st);
    end
  endtask

  task automatic test_random();
    int st;
    int waitc;
    int inv_k;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        fetch_req  = 1'b0;
        fetch_addr = 16'($urandom);
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || fetch_stall !== 1'b0 || instr !== 16'h0) begin
          n_fail++;
          $display("FAIL idle_outputs got=%b%b/%h exp=00/0000", instr_valid, fetch_stall, instr);
        end
        @(negedge clk);
      end
      waitc = $urandom_range(0, 3);
      inv_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 + waitc) : -1;
      do_fetch(16'($urandom_range(0, 16'h01FF)), waitc, inv_k, st);
    end
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_cnt !== 16'(m_hits) || miss_cnt !== 16'(m_misses)) begin
      n_fail++;
      $display("FAIL stats_random got=hit%0d/miss%0d exp=hit%0d/miss%0d", hit_cnt, miss_cnt, m_hits, m_misses);
    end
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_req   = 1'b0;
    fetch_addr  = 16'h0;
    inv_all     = 1'b0;
    mem_rdy     = 1'b0;
    mem_rd_data = 64'h0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_first_fill();
    test_seq_hits();
    test_conflict();
    test_slow_mem();
    test_inv();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
